// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the ram32x4 scan controller.
// The state enum is the single source of truth for the sequencer encoding.
package ram_ctrl_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 4;
    localparam int LAST_ADDR  = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CAPTURE,
        ST_CLEAR
    } state_e;

endpackage : ram_ctrl_pkg

// File: rtl/ram_scan_ctrl_dwell_counter.sv
// Free-running dwell timer for auto-scan: counts enabled cycles and emits a
// one-cycle expire pulse when the count reaches DWELL-1.
module dwell_counter #(
    parameter int DWELL = 50_000_000
) (
    input  logic clock,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CNT_W = $clog2(DWELL);

    logic [CNT_W-1:0] count;

    assign expire = en && (count == CNT_W'(DWELL - 1));

    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr || expire) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : dwell_counter

// File: rtl/ram_scan_ctrl.sv
// Sequencer front end for the 32x4 single-port RAM: write with read-back,
// single read, clear-all and timed auto-scan, feeding the 7-segment displays.
module ram_scan_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DWELL  = 50_000_000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              clr_req,
    input  logic              scan_en,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy
);

    state_e            state, state_n;
    logic [ADDR_W-1:0] tgt, tgt_n;
    logic [DATA_W-1:0] wdata, wdata_n;
    logic [ADDR_W-1:0] disp_addr_n;
    logic [DATA_W-1:0] disp_data_n;
    logic              req_taken;
    logic              dwell_expire;
    logic              is_last;

    assign is_last = (tgt == ADDR_W'(LAST_ADDR));

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clock  (clock),
        .resetn (resetn),
        .en     ((state == ST_IDLE) && scan_en),
        .clr    (req_taken || !scan_en),
        .expire (dwell_expire)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_n     = state;
        tgt_n       = tgt;
        wdata_n     = wdata;
        disp_addr_n = disp_addr;
        disp_data_n = disp_data;
        req_taken   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_n   = ST_CLEAR;
                    tgt_n     = '0;
                    req_taken = 1'b1;
                end else if (wr_req) begin
                    state_n   = ST_WRITE;
                    tgt_n     = cmd_addr;
                    wdata_n   = cmd_data;
                    req_taken = 1'b1;
                end else if (rd_req) begin
                    state_n   = ST_READ;
                    tgt_n     = cmd_addr;
                    req_taken = 1'b1;
                end else if (dwell_expire) begin
                    state_n = ST_READ;
                    tgt_n   = (disp_addr == ADDR_W'(LAST_ADDR)) ? '0
                                                                : disp_addr + ADDR_W'(1);
                end
            end
            ST_WRITE: begin
                state_n = ST_READ;
            end
            ST_READ: begin
                state_n = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                disp_data_n = ram_q;
                disp_addr_n = tgt;
                state_n     = ST_IDLE;
            end
            ST_CLEAR: begin
                tgt_n = tgt + ADDR_W'(1);
                if (is_last) begin
                    disp_addr_n = '0;
                    disp_data_n = '0;
                    state_n     = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            tgt       <= '0;
            wdata     <= '0;
            disp_addr <= '0;
            disp_data <= '0;
        end else begin
            tgt       <= tgt_n;
            wdata     <= wdata_n;
            disp_addr <= disp_addr_n;
            disp_data <= disp_data_n;
        end
    end

    // RAM drive is decoded from state and registers only; in IDLE the RAM
    // keeps pointing at the displayed word.
    always_comb begin
        busy        = (state != ST_IDLE);
        ram_wren    = (state == ST_WRITE) || (state == ST_CLEAR);
        ram_address = (state == ST_IDLE) ? disp_addr : tgt;
        ram_data    = (state == ST_WRITE) ? wdata : '0;
    end

endmodule : ram_scan_ctrl

// File: tb/tb_ram_scan_ctrl.sv
// Self-checking bench for ram_scan_ctrl with a behavioural registered-address
// 32x4 RAM and a reference memory image updated from the operation rules.
module tb_ram_scan_ctrl;

    localparam int AW = 5;
    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic          wr_req, rd_req, clr_req, scan_en;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ram_scan_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DWELL  (4)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .clr_req     (clr_req),
        .scan_en     (scan_en),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .busy        (busy)
    );

    // Behavioural RAM: registered address, unregistered output, plus a
    // bench-only preload port used while the controller is idle.
    logic [DW-1:0] mem [32];
    logic [AW-1:0] q_addr;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_wren) mem[ram_address] <= ram_data;
        q_addr <= ram_address;
    end
    assign ram_q = mem[q_addr];

    // Every RAM write cycle seen by the RAM, as {address, data}.
    logic [AW+DW-1:0] wlog[$];
    always @(negedge clock) if (ram_wren === 1'b1) wlog.push_back({ram_address, ram_data});

    // Reference memory image.
    logic [DW-1:0] ref_mem [32];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_addr = a; cmd_data = d; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        repeat (3) tick();
        ref_mem[a] = d;
    endtask

    task automatic issue_read(input logic [AW-1:0] a);
        cmd_addr = a; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        logic [19:0] exp_vec;
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        exp_vec = '0;
        checks++;
        if ({busy, ram_wren, ram_address, ram_data, disp_addr, disp_data} !== exp_vec) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b wren=%b addr=%0d data=%0d disp=%0d/%0d expected all zero",
                     busy, ram_wren, ram_address, ram_data, disp_addr, disp_data);
        end
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_busy: cycle %0d got %b expected 0", i, busy);
            end
        end
        checks++;
        if (wlog.size() != 0 || disp_addr !== 5'd0 || disp_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle_state: got writes=%0d disp=%0d/%0d expected 0 writes disp 0/0",
                     wlog.size(), disp_addr, disp_data);
        end
    endtask

    task automatic preload_random(input int lo);
        for (int i = 0; i < 32; i++) preload(5'(i), 4'($urandom_range(lo, 15)));
    endtask

    task automatic test_write();
        wlog.delete();
        cmd_addr = 5'd5; cmd_data = 4'hA; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        checks++;
        if ({busy, ram_wren, ram_address, ram_data} !== {1'b1, 1'b1, 5'd5, 4'hA}) begin
            errors++;
            $display("FAIL write_cycle: got busy=%b wren=%b addr=%0d data=%h expected 1 1 5 a",
                     busy, ram_wren, ram_address, ram_data);
        end
        tick();
        checks++;
        if (ram_wren !== 1'b0) begin
            errors++;
            $display("FAIL write_readback_wren: got %b expected 0", ram_wren);
        end
        tick();
        checks++;
        if (disp_addr === 5'd5) begin
            errors++;
            $display("FAIL write_early_disp: got disp_addr=%0d before third edge, expected previous value", disp_addr);
        end
        tick();
        ref_mem[5] = 4'hA;
        checks++;
        if ({busy, disp_addr, disp_data} !== {1'b0, 5'd5, 4'hA}) begin
            errors++;
            $display("FAIL write_disp: got busy=%b disp=%0d/%h expected 0 5/a", busy, disp_addr, disp_data);
        end
        checks++;
        if (wlog.size() != 1 || wlog[0] !== {5'd5, 4'hA}) begin
            errors++;
            $display("FAIL write_wren_count: got %0d write cycles expected exactly 1 at addr 5 data a", wlog.size());
        end
    endtask

    task automatic test_clear();
        int bad;
        issue_write(5'd31, 4'h3);
        checks++;
        if ({disp_addr, disp_data} !== {5'd31, 4'h3}) begin
            errors++;
            $display("FAIL clear_prewrite: got %0d/%h expected 31/3", disp_addr, disp_data);
        end
        wlog.delete();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (busy !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_busy: got %0d cycles with busy low in 32-cycle window expected 0", bad);
        end
        checks++;
        if ({busy, disp_addr, disp_data} !== {1'b0, 5'd0, 4'd0}) begin
            errors++;
            $display("FAIL clear_end: got busy=%b disp=%0d/%h expected 0 0/0", busy, disp_addr, disp_data);
        end
        bad = 0;
        if (wlog.size() != 32) bad++;
        else for (int k = 0; k < 32; k++) if (wlog[k] !== {5'(k), 4'd0}) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_writes: got %0d write cycles (%0d wrong) expected 32 zero writes to 0..31",
                     wlog.size(), bad);
        end
        for (int k = 0; k < 32; k++) ref_mem[k] = '0;
        issue_read(5'd31);
        checks++;
        if ({disp_addr, disp_data} !== {5'd31, 4'd0}) begin
            errors++;
            $display("FAIL clear_readback: got %0d/%h expected 31/0", disp_addr, disp_data);
        end
    endtask

    task automatic test_collision();
        logic [AW-1:0] a, b;
        logic [DW-1:0] d, e;
        a = 5'($urandom_range(0, 31));
        b = 5'((int'(a) + 1 + $urandom_range(0, 30)) % 32);
        d = ref_mem[a] ^ 4'($urandom_range(1, 15));
        e = ref_mem[b] ^ 4'($urandom_range(1, 15));
        wlog.delete();
        cmd_addr = a; cmd_data = d; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        cmd_addr = b; cmd_data = e; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        ref_mem[a] = d;
        checks++;
        if ({disp_addr, disp_data} !== {a, d}) begin
            errors++;
            $display("FAIL collision_disp: got %0d/%h expected %0d/%h", disp_addr, disp_data, a, d);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || wlog.size() != 1 || wlog[0] !== {a, d}) begin
            errors++;
            $display("FAIL collision_writes: got busy=%b writes=%0d expected idle with 1 write to %0d",
                     busy, wlog.size(), a);
        end
        issue_read(b);
        checks++;
        if ({disp_addr, disp_data} !== {b, ref_mem[b]}) begin
            errors++;
            $display("FAIL collision_dropped: got %0d/%h expected %0d/%h", disp_addr, disp_data, b, ref_mem[b]);
        end
    endtask

    task automatic test_scan();
        logic [AW-1:0] cur, nxt;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 32; i++) preload(5'(i), 4'(i % 16));
        wlog.delete();
        cur = 5'd0;
        scan_en = 1'b1;
        for (int i = 0; i < 33; i++) begin
            nxt = (cur == 5'd31) ? 5'd0 : cur + 5'd1;
            repeat (5) tick();
            checks++;
            if (disp_addr !== cur) begin
                errors++;
                $display("FAIL scan_hold: step %0d got %0d expected %0d", i, disp_addr, cur);
            end
            tick();
            checks++;
            if ({disp_addr, disp_data} !== {nxt, ref_mem[nxt]}) begin
                errors++;
                $display("FAIL scan_step: step %0d got %0d/%h expected %0d/%h",
                         i, disp_addr, disp_data, nxt, ref_mem[nxt]);
            end
            cur = nxt;
        end
        scan_en = 1'b0;
        checks++;
        if (wlog.size() != 0) begin
            errors++;
            $display("FAIL scan_no_write: got %0d write cycles expected 0", wlog.size());
        end
    endtask

    task automatic test_reset_during_clear();
        preload_random(1);
        wlog.delete();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if ({busy, ram_wren, disp_addr, disp_data} !== {1'b0, 1'b0, 5'd0, 4'd0}) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b wren=%b disp=%0d/%h expected 0 0 0/0",
                     busy, ram_wren, disp_addr, disp_data);
        end
        checks++;
        if (wlog.size() != 10) begin
            errors++;
            $display("FAIL abort_write_count: got %0d expected 10", wlog.size());
        end
        for (int k = 0; k < 10; k++) ref_mem[k] = '0;
        for (int k = 0; k < 11; k++) begin
            issue_read(5'(k));
            checks++;
            if (disp_data !== ref_mem[k]) begin
                errors++;
                $display("FAIL abort_read_%0d: got %h expected %h", k, disp_data, ref_mem[k]);
            end
        end
        issue_read(5'd20);
        checks++;
        if (disp_data !== ref_mem[20]) begin
            errors++;
            $display("FAIL abort_read_20: got %h expected %h", disp_data, ref_mem[20]);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            n_exp;
        for (int i = 0; i < 40; i++) begin
            a = 5'($urandom_range(0, 31));
            d = 4'($urandom_range(0, 15));
            wlog.delete();
            if ($urandom_range(0, 1) == 0) begin
                issue_write(a, d);
                n_exp = 1;
            end else begin
                issue_read(a);
                n_exp = 0;
            end
            checks++;
            if ({disp_addr, disp_data} !== {a, ref_mem[a]} || wlog.size() != n_exp) begin
                errors++;
                $display("FAIL random_op_%0d: got %0d/%h writes=%0d expected %0d/%h writes=%0d",
                         i, disp_addr, disp_data, wlog.size(), a, ref_mem[a], n_exp);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        resetn = 1'b0; wr_req = 1'b0; rd_req = 1'b0; clr_req = 1'b0; scan_en = 1'b0;
        cmd_addr = '0; cmd_data = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        test_reset();
        preload_random(0);
        test_write();
        test_clear();
        preload_random(0);
        test_collision();
        test_scan();
        test_reset_during_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram_scan_ctrl

// File: doc/ram_scan_ctrl.md
# ram_scan_ctrl

Sequencing front end for the 32x4 single-port RAM (`ram32x4`). Drives the RAM's address, data and write-enable inputs and captures its read port. Supports single writes with read-back, single reads, a full-array clear, and an auto-scan mode that steps through addresses at a programmable dwell. Its `disp_addr`/`disp_data` outputs feed the existing 7-segment `DECODER` instances.

## Interface
- `ADDR_W`, 5: RAM address width (32 words).
- `DATA_W`, 4: RAM word width.
- `DWELL`, 50_000_000: clock cycles spent on each address in scan mode; must be ≥ 2.

- `clock`  in  1  single clock; RAM clocked on the same edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `wr_req`  in  1  write request, level-sampled in IDLE.
- `rd_req`  in  1  read request, level-sampled in IDLE.
- `clr_req`  in  1  clear-all request, level-sampled in IDLE.
- `scan_en`  in  1  enables auto-scan while idle.
- `cmd_addr`  in  ADDR_W  target address for `wr_req`/`rd_req`.
- `cmd_data`  in  DATA_W  write data for `wr_req`.
- `ram_address`  out  ADDR_W  to RAM `address`.
- `ram_data`  out  DATA_W  to RAM `data`.
- `ram_wren`  out  1  to RAM `wren`.
- `ram_q`  in  DATA_W  from RAM `q` (address registered, output unregistered: valid one cycle after address is presented).
- `disp_addr`  out  ADDR_W  address of the last captured word.
- `disp_data`  out  DATA_W  last captured word.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WRITE, READ, CAPTURE, CLEAR. Register `tgt` holds the current target address.
- IDLE: `ram_wren`=0, `ram_address`=`disp_addr`. Priority on each edge: `clr_req` > `wr_req` > `rd_req` > dwell expiry.
  - `clr_req`: go to CLEAR with `tgt`=0.
  - `wr_req`: latch `cmd_addr`/`cmd_data`, go to WRITE.
  - `rd_req`: latch `cmd_addr`, go to READ.
  - Dwell expiry: `tgt`=`disp_addr`+1, wrapping 31→0; go to READ.
- WRITE: `ram_wren`=1, address and data taken from the latched values; go to READ on the same `tgt` (read-back).
- READ: `ram_wren`=0, `ram_address`=`tgt`; go to CAPTURE.
- CAPTURE: `disp_data`←`ram_q`, `disp_addr`←`tgt`; go to IDLE.
- CLEAR: `ram_wren`=1, `ram_data`=0, `ram_address`=`tgt`, `tgt` increments each cycle. After writing address 31: `disp_addr`←0, `disp_data`←0, go to IDLE. Exactly 32 write cycles.
- Dwell counter: counts only in IDLE with `scan_en`=1. Expires when the count equals `DWELL`-1. Clears to 0 on expiry, on any accepted request, or when `scan_en`=0.
- Requests arriving while `busy`=1 are dropped, not queued. A request held high is re-accepted on each return to IDLE.

## Timing
- Reset values: state IDLE; `disp_addr`=0, `disp_data`=0, `tgt`=0, counter=0, `busy`=0, `ram_wren`=0, `ram_data`=0, `ram_address`=0.
- All outputs are registered or decoded from state only; there is no combinational input→output path.
- Write latency: request sampled at edge E0; WRITE occupies the cycle after E0; displays update at E3; IDLE at E3.
- Read latency: request sampled at E0; displays update at E2.
- Scan period: one address per `DWELL`+2 cycles.
- Clear: `busy` high for 32 cycles; IDLE at E32.
- Reset during CLEAR or WRITE: return to IDLE at the next edge. RAM contents already written stay as written; there is no rollback.
- Requests arriving simultaneously: only the highest-priority request is acted on; the others are dropped.

## Structure
- Package `ram_ctrl_pkg`: state enum (IDLE, WRITE, READ, CAPTURE, CLEAR), `ADDR_W`/`DATA_W` defaults, `LAST_ADDR`=31.
- Sub-module `dwell_counter` (parameter `DWELL`; inputs `en`, `clr`; output `expire` as a one-cycle pulse).
- The FSM and datapath live in `ram_scan_ctrl`. The bench instantiates a behavioural 32x4 RAM with registered address.

## Test plan
- Reset, then idle 10 cycles → `disp_addr`=0, `disp_data`=0, `busy`=0, `ram_wren` never asserted.
- `wr_req` with `cmd_addr`=5, `cmd_data`=0xA → `ram_wren` high for exactly 1 cycle at address 5; 3 edges later `disp_addr`=5, `disp_data`=0xA.
- Write 0x3 to address 31, then `clr_req` → 32 consecutive `wren` cycles on addresses 0..31 with data 0; then `rd_req` on address 31 → `disp_data`=0.
- `DWELL`=4, `scan_en`=1, RAM preloaded so word n = n mod 16 → `disp_addr` sequence 1,2,…,31,0,1 with a 6-cycle period; `disp_data` tracks the preload.
- `wr_req` and `rd_req` asserted on the same edge, plus a second `wr_req` pulsed while `busy` → only the first write executes; the dropped request never reaches the RAM.
- `resetn` low at cycle 10 of a CLEAR → IDLE next edge; addresses 0–9 read as 0, address 20 retains its prior value.
